fir_mac_ctrl: RTL and testbench

//  Sequencer for the serial (one multiply per cycle) FIR MAC datapath.
//  - Accepts input samples over a valid/ready handshake.
//  - Writes each sample into a circular sample RAM.
//  - Steps the coefficient/sample read addresses through all taps.
//  - Drives load and first-product control of the 38-bit accumulator register.
//  - Presents the finished sum over a valid/ready output handshake.

---
 rtl/fir_mac_ctrl.sv | 143 ++++++++++++++
 tb/tb_fir_mac_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_ctrl
// Purpose  : Sequencer for a serial FIR MAC: sample intake, tap address walk,
//            accumulator load control and output handshake.
// Revision : 1.0  initial release
// ============================================================================
module fir_mac_ctrl #(
  parameter int TAPS    = 64,
  parameter int MAC_LAT = 2,
  parameter int AW      = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sample_we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] rd_addr_x,
  output logic [AW-1:0] rd_addr_c,
  output logic          rd_zero,
  output logic          acc_load,
  output logic          acc_first,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int              c_DW       = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0]   c_K_LAST   = AW'(TAPS - 1);
  localparam logic [AW:0]     c_FILL_MAX = (AW+1)'(TAPS);
  localparam logic [c_DW-1:0] c_D_LAST   = c_DW'(MAC_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_k;
  logic [AW:0]        r_fill;
  logic [c_DW-1:0]    r_dcnt;
  logic [MAC_LAT-1:0] r_pipe_ld;
  logic [MAC_LAT-1:0] r_pipe_first;
  logic               w_accept;
  logic               w_issue;
  logic               w_k_last;
  logic               w_out_fire;
  logic [AW-1:0]      w_xaddr;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_issue    = (r_state == S_MAC);
  assign w_k_last   = (r_k == c_K_LAST);
  assign w_out_fire = (r_state == S_OUT) && out_ready;

  // Newest sample sits at wptr; tap k reads k samples back, wrapping modulo TAPS.
  always_comb begin
    w_xaddr = '0;
    if (r_wptr >= r_k) begin
      w_xaddr = r_wptr - r_k;
    end else begin
      w_xaddr = AW'(({1'b0, r_wptr} + c_FILL_MAX) - {1'b0, r_k});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    sample_we   = 1'b0;
    waddr       = r_wptr;
    rd_addr_x   = '0;
    rd_addr_c   = '0;
    rd_zero     = 1'b0;
    acc_load    = r_pipe_ld[MAC_LAT-1];
    acc_first   = r_pipe_first[MAC_LAT-1];
    out_valid   = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready  = 1'b1;
        sample_we = in_valid;
        if (in_valid) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        rd_addr_c = r_k;
        rd_addr_x = w_xaddr;
        rd_zero   = ({1'b0, r_k} >= r_fill);
        if (w_k_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_dcnt == c_D_LAST) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_k          <= '0;
      r_fill       <= '0;
      r_dcnt       <= '0;
      r_pipe_ld    <= '0;
      r_pipe_first <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_k <= '0;
        if (r_fill != c_FILL_MAX) r_fill <= r_fill + 1'b1;
      end else if (r_state == S_MAC) begin
        r_k <= w_k_last ? '0 : r_k + 1'b1;
      end

      if (r_state == S_DRAIN) begin
        r_dcnt <= (r_dcnt == c_D_LAST) ? '0 : r_dcnt + 1'b1;
      end

      if (w_out_fire) begin
        r_wptr <= (r_wptr == c_K_LAST) ? '0 : r_wptr + 1'b1;
      end

      // Load pipe aligns each issued tap with its product at the accumulator.
      r_pipe_ld[0]    <= w_issue;
      r_pipe_first[0] <= w_issue && (r_k == '0);
      for (int i = 1; i < MAC_LAT; i++) begin
        r_pipe_ld[i]    <= r_pipe_ld[i-1];
        r_pipe_first[i] <= r_pipe_first[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_ctrl
// Purpose  : Self-checking bench for fir_mac_ctrl with RAM/ROM/MAC models.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_mac_ctrl;

  localparam int TAPS    = 4;
  localparam int MAC_LAT = 2;
  localparam int AW      = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sample_we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] rd_addr_x;
  logic [AW-1:0] rd_addr_c;
  logic          rd_zero;
  logic          acc_load;
  logic          acc_first;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  int            din;

  fir_mac_ctrl #(.TAPS(TAPS), .MAC_LAT(MAC_LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sample_we(sample_we), .waddr(waddr), .rd_addr_x(rd_addr_x),
    .rd_addr_c(rd_addr_c), .rd_zero(rd_zero), .acc_load(acc_load),
    .acc_first(acc_first), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Datapath models: sample RAM, coefficient ROM c[k]=k+1, MAC_LAT product delay, accumulator.
  int ram [TAPS];
  int p1, p2, acc;
  always @(posedge clk) begin
    if (sample_we) ram[waddr] <= din;
    p1 <= rd_zero ? 0 : ram[rd_addr_x] * (int'(rd_addr_c) + 1);
    p2 <= p1;
    if (acc_load) acc <= acc_first ? p2 : acc + p2;
  end

  // Behavioural model: frame timing by offset from the accept cycle, value by direct convolution.
  int cyc = 0;
  int m_T = 0;
  bit m_idle = 1'b1;
  int m_wptr = 0;
  int m_fill = 0;
  int m_nacc = 0;
  bit seen_ov = 1'b0;
  int held = 0;
  int hist[$];
  int got_q[$];
  int waddr_q[$];
  int rdx6[4];
  int rdz1[4];

  function automatic int exp_sum();
    int s = 0;
    int n = hist.size();
    for (int k = 0; k < TAPS; k++)
      if (n - 1 - k >= 0) s += (k + 1) * hist[n-1-k];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_acc_load", int'(acc_load), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      m_idle = 1'b1; m_wptr = 0; m_fill = 0; m_nacc = 0;
      hist.delete();
    end else begin
      int d, k;
      bit ov_e, ld_e, first_e, mac_e, we_e;
      d       = cyc - m_T;
      k       = d - 1;
      ov_e    = !m_idle && d >= TAPS + MAC_LAT + 1;
      ld_e    = !m_idle && d >= 1 + MAC_LAT && d <= TAPS + MAC_LAT;
      first_e = !m_idle && d == 1 + MAC_LAT;
      mac_e   = !m_idle && d >= 1 && d <= TAPS;
      we_e    = m_idle && in_valid;

      chk("in_ready", int'(in_ready), int'(m_idle));
      chk("busy", int'(busy), int'(!m_idle));
      chk("out_valid", int'(out_valid), int'(ov_e));
      chk("acc_load", int'(acc_load), int'(ld_e));
      chk("acc_first", int'(acc_first), int'(first_e));
      chk("sample_we", int'(sample_we), int'(we_e));
      if (mac_e) begin
        chk("rd_addr_c", int'(rd_addr_c), k);
        chk("rd_addr_x", int'(rd_addr_x), (m_wptr - k + TAPS) % TAPS);
        chk("rd_zero", int'(rd_zero), int'(k >= m_fill));
        if (m_nacc == 6) rdx6[k] = int'(rd_addr_x);
        if (m_nacc == 1) rdz1[k] = int'(rd_zero);
      end else begin
        chk("rd_idle", int'({rd_addr_c, rd_addr_x, rd_zero}), 0);
      end
      if (!m_idle && out_valid && !seen_ov) begin
        seen_ov = 1'b1;
        chk("latency", d, 7);
      end
      if (ov_e) chk("out_value", acc, exp_sum());
      if (out_valid && !out_ready) held++;

      if (we_e) begin
        chk("waddr", int'(waddr), m_wptr);
        waddr_q.push_back(int'(waddr));
        hist.push_back(din);
        if (m_fill < TAPS) m_fill++;
        m_nacc++;
        m_idle  = 1'b0;
        m_T     = cyc;
        seen_ov = 1'b0;
      end else if (ov_e && out_ready) begin
        got_q.push_back(acc);
        m_idle = 1'b1;
        m_wptr = (m_wptr + 1) % TAPS;
      end
    end
    cyc++;
  end

  task automatic send(input int v);
    int n = 0;
    din = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", int'(n < 200), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("out_timeout", int'(n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int imp_in [6]  = '{1, 0, 0, 0, 0, 0};
    int imp_out [6] = '{1, 2, 3, 4, 0, 0};
    int wa_exp [9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int rdx_exp [4] = '{1, 0, 3, 2};
    int rdz_exp [4] = '{0, 1, 1, 1};
    int n;
    rst = 1'b0; in_valid = 1'b0; din = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Priming after reset
    got_q.delete();
    send(5); wait_out();
    for (int i = 0; i < 4; i++) chk("prime_rd_zero", rdz1[i], rdz_exp[i]);
    send(1); wait_out();
    chk("prime_out0", got_q[0], 5);
    chk("prime_out1", got_q[1], 11);

    // Impulse response
    do_reset();
    got_q.delete();
    for (int i = 0; i < 6; i++) begin send(imp_in[i]); wait_out(); end
    for (int i = 0; i < 6; i++) chk("impulse_out", got_q[i], imp_out[i]);

    // Output backpressure with a pending input held valid
    got_q.delete();
    held = 0;
    out_ready = 1'b0;
    send(3);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_ov_timeout", int'(n < 100), 1);
    din = 7; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_out();
    send(7); wait_out();
    chk("bp_held", int'(held >= 10), 1);
    chk("bp_out0", got_q[0], 3);
    chk("bp_out1", got_q[1], 13);

    // Write-pointer wrap
    do_reset();
    waddr_q.delete();
    for (int i = 1; i <= 9; i++) begin send(i); wait_out(); end
    for (int i = 0; i < 9; i++) chk("wrap_waddr", waddr_q[i], wa_exp[i]);
    for (int i = 0; i < 4; i++) chk("wrap_rd_addr_x", rdx6[i], rdx_exp[i]);

    // Reset during k=2 of a frame
    send(9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    waddr_q.delete(); got_q.delete();
    send(2); wait_out();
    chk("midrst_waddr", waddr_q[0], 0);
    for (int i = 0; i < 4; i++) chk("midrst_rd_zero", rdz1[i], rdz_exp[i]);
    chk("midrst_out", got_q[0], 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
